// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: NRD asynchronous read ports, one write port, clear status.
// Handshake: no flow control. we qualifies waddr/wdata for the coming edge; ready is a level.
interface regfile_mp_if #(
  parameter int DW    = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic              we;
  logic              ready;
  logic              wr_drop;

  modport master (
    output raddr, waddr, wdata, we,
    input  rdata, ready, wr_drop
  );

  modport slave (
    input  raddr, waddr, wdata, we,
    output rdata, ready, wr_drop
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a post-reset self-clearing sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus,
  output logic [0:0]   dbg_state
);
  localparam int AW = $clog2(NREGS);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DW-1:0]     mem_q [NREGS];

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DW-1:0]     mem_wdata;
  logic              wr_to_zero;
  logic [NRD*DW-1:0] rdata_w;

  assign wr_to_zero = (ZERO_REG != 0) && (bus.waddr == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.waddr;
    mem_wdata = bus.wdata;
    if (state_q == S_CLEAR) begin
      // The sweep owns the write port; any requested write is reported as dropped.
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      wr_drop_d = bus.we;
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      mem_we = bus.we && !wr_to_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_CLEAR;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Contents are deliberately left alone by reset; the sweep zeroes them afterwards.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rdata_w = '0;
    for (int i = 0; i < NRD; i++) begin
      if ((state_q == S_RUN) &&
          !((ZERO_REG != 0) && (bus.raddr[i*AW +: AW] == '0))) begin
        rdata_w[i*DW +: DW] = mem_q[bus.raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (bus.we && (bus.raddr[i*AW +: AW] == bus.waddr)) begin
          rdata_w[i*DW +: DW] = bus.wdata;
        end
`endif
      end
    end
  end

  assign bus.rdata   = rdata_w;
  assign bus.ready   = (state_q == S_RUN);
  assign bus.wr_drop = wr_drop_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (ZERO_REG=1 and ZERO_REG=0) driven by identical stimulus,
// checked against an array model plus a table of directed vectors and hand-written corner cases.
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int AW    = $clog2(NREGS);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRD*AW-1:0] raddr;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic              we;
  logic [0:0]        dbg_z, dbg_n;

  regfile_mp_if #(.DW(DW), .NREGS(NREGS), .NRD(NRD)) bus_z ();
  regfile_mp_if #(.DW(DW), .NREGS(NREGS), .NRD(NRD)) bus_n ();

  assign bus_z.raddr = raddr;
  assign bus_z.waddr = waddr;
  assign bus_z.wdata = wdata;
  assign bus_z.we    = we;
  assign bus_n.raddr = raddr;
  assign bus_n.waddr = waddr;
  assign bus_n.wdata = wdata;
  assign bus_n.we    = we;

  regfile_mp #(.DW(DW), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst_n), .bus(bus_z.slave), .dbg_state(dbg_z));
  regfile_mp #(.DW(DW), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst(rst_n), .bus(bus_n.slave), .dbg_state(dbg_n));

  // clock / reset
  always #5 clk = ~clk;

  // reference model: m_clr counts clear edges since the last reset edge
  logic [DW-1:0] m_mem [2][NREGS];
  int            m_clr;
  logic          m_drop;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct packed {
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int d, input logic [AW-1:0] a);
    if (m_clr < NREGS) return '0;
    if (d == 0 && a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && a == waddr) return wdata;
`endif
    return m_mem[d][a];
  endfunction

  // driver: one clock edge, model update at the edge, return at the falling edge
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_clr  = 0;
      m_drop = 1'b0;
    end else if (m_clr < NREGS) begin
      m_mem[0][m_clr] = '0;
      m_mem[1][m_clr] = '0;
      m_clr++;
      m_drop = we;
    end else begin
      m_drop = 1'b0;
      if (we) begin
        if (waddr != '0) m_mem[0][waddr] = wdata;
        m_mem[1][waddr] = wdata;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_ra(input int a0, input int a1, input int a2);
    raddr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  // scoreboard: expected values queued from the model, popped against the outputs
  task automatic check_model(input string tag);
    logic [DW-1:0] act [10];
    string lbl [5];
    lbl = '{"ready", "wr_drop", "rd0", "rd1", "rd2"};
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_q.push_back(DW'(m_clr >= NREGS));
      exp_q.push_back(DW'(m_drop));
      for (int p = 0; p < NRD; p++) exp_q.push_back(exp_rd(d, raddr[p*AW +: AW]));
    end
    act[0] = DW'(bus_z.ready);
    act[1] = DW'(bus_z.wr_drop);
    act[5] = DW'(bus_n.ready);
    act[6] = DW'(bus_n.wr_drop);
    for (int p = 0; p < NRD; p++) begin
      act[2+p] = bus_z.rdata[p*DW +: DW];
      act[7+p] = bus_n.rdata[p*DW +: DW];
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s.%s.%s", tag, (k < 5) ? "z" : "n", lbl[k % 5]), act[k], exp_q.pop_front());
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < NREGS; r++) m_mem[d][r] = '0;
    m_clr  = 0;
    m_drop = 1'b0;

    vecs[0] = '{1'b1, 5'd5,  32'h12345678, {5'd3, 5'd2, 5'd1},  {32'h0, 32'h0, 32'h0}};
    vecs[1] = '{1'b1, 5'd6,  32'hCAFEF00D, {5'd0, 5'd1, 5'd5},  {32'h0, 32'h0, 32'h12345678}};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        {5'd5, 5'd6, 5'd5},  {32'h12345678, 32'hCAFEF00D, 32'h12345678}};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, {5'd6, 5'd5, 5'd6},  {32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D}};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        {5'd6, 5'd0, 5'd0},  {32'hCAFEF00D, 32'h0, 32'h0}};
    vecs[5] = '{1'b1, 5'd31, 32'h0BADF00D, {5'd6, 5'd5, 5'd0},  {32'hCAFEF00D, 32'h12345678, 32'h0}};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        {5'd31, 5'd0, 5'd31}, {32'h0BADF00D, 32'h0, 32'h0BADF00D}};

    // reset state
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    tick(); tick();
    check_model("reset");
    chk("reset_ready", DW'(bus_z.ready), 32'h0);
    chk("reset_wr_drop", DW'(bus_z.wr_drop), 32'h0);

    // first clear sweep
    rst_n = 1'b1;
    set_ra(1, 2, 3);
    for (int i = 1; i <= NREGS; i++) begin
      tick();
      check_model("clear1");
      chk($sformatf("clear1_ready_e%0d", i), DW'(bus_z.ready), DW'(i == NREGS));
    end

    // preload every register, then reset and clear again with a write on the 3rd clear edge
    for (int a = 1; a < NREGS; a++) begin
      we = 1'b1; waddr = AW'(a); wdata = 32'hDEADBEEF;
      tick();
    end
    we = 1'b0;
    set_ra(1, 7, 31);
    check_model("preload");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= NREGS; i++) begin
      we = (i == 3); waddr = 5'd7; wdata = 32'hAA;
      check_model("clear2_pre");
      tick();
      check_model("clear2");
      chk($sformatf("clear2_ready_e%0d", i), DW'(bus_z.ready), DW'(i == NREGS));
      if (i == 3) chk("clear_write_drop", DW'(bus_z.wr_drop), 32'h1);
      if (i == 4) chk("clear_write_drop_end", DW'(bus_z.wr_drop), 32'h0);
    end
    we = 1'b0;
    for (int a = 1; a < NREGS; a += 3) begin
      set_ra(a, (a + 1 > 31) ? 31 : a + 1, (a + 2 > 31) ? 31 : a + 2);
      check_model("cleared");
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("cleared_z_x%0d", raddr[p*AW +: AW]), bus_z.rdata[p*DW +: DW], 32'h0);
        chk($sformatf("cleared_n_x%0d", raddr[p*AW +: AW]), bus_n.rdata[p*DW +: DW], 32'h0);
      end
    end

    // directed vectors, read values compared before each row's write edge
    for (int v = 0; v < 7; v++) begin
      we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata; raddr = vecs[v].ra;
      check_model($sformatf("vec%0d", v));
      for (int p = 0; p < NRD; p++)
        chk($sformatf("vec%0d_rd%0d", v, p), bus_z.rdata[p*DW +: DW], vecs[v].exp[p*DW +: DW]);
      tick();
      chk($sformatf("vec%0d_wr_drop", v), DW'(bus_z.wr_drop), 32'h0);
    end

    // x0 with and without the zero register
    we = 1'b0; set_ra(0, 0, 0);
    #1;
    chk("x0_zero_reg1", bus_z.rdata[DW-1:0], 32'h0);
    chk("x0_zero_reg0", bus_n.rdata[DW-1:0], 32'hFFFFFFFF);

    // same-cycle read/write of x9
    we = 1'b1; waddr = 5'd9; wdata = 32'h1;
    tick();
    wdata = 32'h2; set_ra(9, 9, 9);
    check_model("rw_same");
`ifdef REGFILE_BYPASS_EN
    chk("rw_same_cycle", bus_z.rdata[DW-1:0], 32'h2);
`else
    chk("rw_same_cycle", bus_z.rdata[DW-1:0], 32'h1);
`endif
    tick();
    we = 1'b0;
    check_model("rw_next");
    chk("rw_next_cycle", bus_z.rdata[2*DW +: DW], 32'h2);

    // reset on the 10th clear edge restarts the full sweep
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= NREGS; i++) begin
      tick();
      check_model("restart");
      chk($sformatf("restart_ready_e%0d", i), DW'(bus_n.ready), DW'(i == NREGS));
    end

    // randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      we    = $urandom_range(0, 1);
      waddr = AW'($urandom_range(0, NREGS - 1));
      wdata = $urandom;
      for (int p = 0; p < NRD; p++)
        raddr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NREGS - 1));
      check_model($sformatf("rand%0d", c));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
